// File: rtl/matmul_sequencer_pkg.sv
// Shared constants and types for the 2x2 minifloat matrix-multiply sequencer.
package matmul_sequencer_pkg;

   // Default element width: 1 sign, 3-bit exponent (bias 3), 4-bit mantissa
   localparam int unsigned EW    = 8;
   localparam int unsigned DIM   = 2;
   localparam int unsigned NELEM = DIM * DIM;

   typedef enum logic [2:0] {
      StIdle,
      StMul0,
      StMul1,
      StAdd,
      StDone
   } state_t;

   // Flat element number for [row][col], indexed by {row, col}; slice LSB is ELEM_IDX * EW
   localparam logic [NELEM-1:0][1:0] ELEM_IDX = {2'd3, 2'd2, 2'd1, 2'd0};

endpackage

// File: rtl/matmul_operand_mux.sv
// Selects A[i][n] and B[n][j] from the latched operand matrices for element k = {i, j}.
module matmul_operand_mux #(
   parameter int unsigned EW = 8
) (
   input  logic [4*EW-1:0] a_reg,
   input  logic [4*EW-1:0] b_reg,
   input  logic [1:0]      k,
   input  logic            n,
   output logic [EW-1:0]   a_op,
   output logic [EW-1:0]   b_op
);
   import matmul_sequencer_pkg::*;

   logic [1:0] a_sel;
   logic [1:0] b_sel;

   // Row of A comes from i = k[1], column of B from j = k[0]; n walks the inner dimension
   always_comb begin
      a_sel = ELEM_IDX[{k[1], n}];
      b_sel = ELEM_IDX[{n, k[0]}];
      a_op  = a_reg[int'(a_sel)*EW +: EW];
      b_op  = b_reg[int'(b_sel)*EW +: EW];
   end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences a 2x2 matrix product C = A x B through one external multiplier and one
// external adder: two multiplies and one add per element, elements in order C00..C11.
module matmul_sequencer #(
   parameter int unsigned EW = matmul_sequencer_pkg::EW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4*EW-1:0] a_mat,
   input  logic [4*EW-1:0] b_mat,
   output logic [EW-1:0]   mul_a,
   output logic [EW-1:0]   mul_b,
   input  logic [EW-1:0]   mul_p,
   output logic [EW-1:0]   add_a,
   output logic [EW-1:0]   add_b,
   input  logic [EW-1:0]   add_s,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4*EW-1:0] c_mat
);
   import matmul_sequencer_pkg::*;

   state_t          state;
   logic [1:0]      k;
   logic [EW-1:0]   p0;
   logic [EW-1:0]   p1;
   logic [4*EW-1:0] a_reg;
   logic [4*EW-1:0] b_reg;
   logic [4*EW-1:0] c_reg;
   logic [EW-1:0]   op_a;
   logic [EW-1:0]   op_b;
   logic            n_sel;

   // Inner-dimension index: 0 for the first partial product, 1 for the second
   assign n_sel = (state == StMul1);

   matmul_operand_mux #(
      .EW (EW)
   ) u_operand_mux (
      .a_reg (a_reg),
      .b_reg (b_reg),
      .k     (k),
      .n     (n_sel),
      .a_op  (op_a),
      .b_op  (op_b)
   );

   // Arithmetic unit operands are gated to zero outside the states that use them
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      add_a = '0;
      add_b = '0;
      if (state == StMul0 || state == StMul1) begin
         mul_a = op_a;
         mul_b = op_b;
      end
      if (state == StAdd) begin
         add_a = p0;
         add_b = p1;
      end
   end

   // Result matrix is always visible; it only changes in the ADD state
   assign c_mat = c_reg;

   // Sequencer FSM with registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         k         <= '0;
         p0        <= '0;
         p1        <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         c_reg     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (in_valid && in_ready) begin
                  a_reg    <= a_mat;
                  b_reg    <= b_mat;
                  k        <= '0;
                  in_ready <= 1'b0;
                  state    <= StMul0;
               end
            end
            StMul0: begin
               p0    <= mul_p;
               state <= StMul1;
            end
            StMul1: begin
               p1    <= mul_p;
               state <= StAdd;
            end
            StAdd: begin
               c_reg[int'(ELEM_IDX[k])*EW +: EW] <= add_s;
               if (k == 2'd3) begin
                  out_valid <= 1'b1;
                  state     <= StDone;
               end else begin
                  k     <= k + 2'd1;
                  state <= StMul0;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= StIdle;
               end
            end
            default: begin
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               state     <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-002 Parameter EW, default 8, element width in minifloat format (1 sign, 3-bit exponent biased by 3, 4-bit mantissa with hidden leading 1).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operand matrices present.
REQ-006 in_ready  output  1  block accepts operand matrices.
REQ-007 a_mat, b_mat  input  4*EW each  2x2 matrices; element [i][j] at bits [(2i+j)*EW +: EW].
REQ-008 mul_a, mul_b  output  EW each  operands to the external combinational minifloat multiplier.
REQ-009 mul_p  input  EW  product returned by that multiplier in the same cycle.
REQ-010 add_a, add_b  output  EW each  operands to the external combinational minifloat adder.
REQ-011 add_s  input  EW  sum returned by that adder in the same cycle.
REQ-012 out_valid  output  1  result matrix valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 c_mat  output  4*EW  result C = A x B, same element packing as a_mat.

Function
REQ-015 States SHALL be IDLE, MUL0, MUL1, ADD, DONE; the element index k (0..3, i = k[1], j = k[0]) is a 2-bit counter.
REQ-016 in_ready SHALL be 1 in IDLE only; a transfer occurs when in_valid and in_ready are both 1 on a clock edge.
REQ-017 On a transfer, a_mat and b_mat SHALL be latched into internal registers, k SHALL be cleared, and the state SHALL go to MUL0; input changes after the transfer have no effect.
REQ-018 MUL0: mul_a = A[i][0], mul_b = B[0][j]; mul_p SHALL be registered as p0; next state MUL1.
REQ-019 MUL1: mul_a = A[i][1], mul_b = B[1][j]; mul_p SHALL be registered as p1; next state ADD.
REQ-020 ADD: add_a = p0, add_b = p1; add_s SHALL be written into C[i][j]; if k = 3 the next state is DONE, otherwise k increments and the next state is MUL0.
REQ-021 Outside MUL0/MUL1, mul_a and mul_b SHALL be 0; outside ADD, add_a and add_b SHALL be 0.
REQ-022 Elements SHALL be computed in the order C00, C01, C10, C11; latency from the transfer edge to out_valid = 1 is exactly 12 cycles.
REQ-023 DONE: out_valid = 1 and c_mat stable; c_mat SHALL hold its value until out_ready = 1, then the state returns to IDLE.
REQ-024 c_mat SHALL be driven from the result registers at all times and SHALL only be written in ADD.
REQ-025 out_ready outside DONE SHALL be ignored; in_valid outside IDLE SHALL be ignored and SHALL NOT corrupt the latched operands.
REQ-026 Back-to-back use: after the out_ready edge in DONE, in_ready SHALL be 1 on the next cycle; no operation may overlap another.
REQ-027 The block performs no arithmetic itself; sign, exponent clamp and overflow behaviour belong entirely to the external units.

Reset
REQ-028 On rst = 1 at a clock edge, the state SHALL become IDLE, k = 0, p0 = p1 = 0, the operand registers and c_mat = 0, out_valid = 0, and in_ready = 1 on the following cycle.
REQ-029 A reset in any state, including mid-sequence and in DONE with out_ready low, SHALL abort the operation without emitting out_valid.

Structure
REQ-030 A shared package SHALL hold EW, the matrix dimension (2), the state enumeration, and an element-slice index helper constant table.
REQ-031 One sub-module, matmul_operand_mux, SHALL select A[i][n] and B[n][j] from the latched registers given k and n; the multiplier and adder remain outside the block.

Verification
REQ-032 Single op: A = {30,30,30,30}, B = {40,30,38,30} (hex, element order 00,01,10,11), stub multiply/add units -> mul operand pairs in order (30,40),(30,38),(30,30),(30,30),(30,40),(30,38),(30,30),(30,30); out_valid rises 12 cycles after the transfer.
REQ-033 Backpressure: hold out_ready = 0 for 5 cycles in DONE -> out_valid stays 1, c_mat constant, in_ready stays 0; it releases on the first out_ready = 1.
REQ-034 Input isolation: toggle a_mat/b_mat and in_valid during MUL1 of k = 1 -> results equal the values from the undisturbed run.
REQ-035 Reset mid-op: assert rst in the ADD state of k = 2 -> the next cycle shows IDLE, in_ready = 1, c_mat = 0, and out_valid never pulses.
REQ-036 Back-to-back: in_valid held high with out_ready = 1 -> a second transfer occurs 1 cycle after the first DONE, with a 14-cycle period per op.
REQ-037 Golden model: 50 random operand pairs against a reference matrix product built from the same multiply/add models -> all c_mat bit-exact.
